// File: rtl/uart_pkg.sv
// Shared UART types and timing constants for the configurable receiver
// (and the future configurable transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    FLUSH  = 3'd5
  } uart_rx_state_e;

  // One bit period is SUBTICKS sub-ticks of 'prescale' clocks each.
  localparam int SUBTICKS = 8;

  // Sub-tick offsets inside a bit where the line is sampled.
  localparam int SAMPLE_A = 3;
  localparam int SAMPLE_B = 4;
  localparam int SAMPLE_C = 5;

  // 16-bit prescale times 8 sub-ticks.
  localparam int CNT_W = 19;

endpackage

// File: rtl/uart_rx_cfg_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops resolve metastability before the value is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_WIDTH data bits, optional parity,
// one or two stop bits, 3-sample majority vote per bit, false-start
// rejection, AXI-stream output with a one-word holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           prescale,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error
);

  localparam parity_mode_e PMODE     = parity_mode_e'(PARITY_MODE[1:0]);
  localparam logic [3:0]   LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic         LAST_STOP = (STOP_BITS == 2);

  logic rxs;
  logic rxs_prev_q;

  uart_rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             p_q, p_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [3:0]              bit_q, bit_d;
  logic                    stop_idx_q, stop_idx_d;
  logic                    stop_bad_q, stop_bad_d;
  logic                    s_a_q, s_a_d;
  logic                    s_b_q, s_b_d;
  logic                    par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ovr_q, ovr_d;
  logic                    ferr_q, ferr_d;
  logic                    perr_q, perr_d;

  logic [CNT_W-1:0] p_ext;
  logic [CNT_W-1:0] t_a, t_b, t_c, t_end;
  logic             at_a, at_b, at_c, bit_end;
  logic             decided;
  logic             parity_bad;
  logic             stop_bad_now;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  // Bit-relative sample points derived from the prescale captured at start.
  assign p_ext   = {3'b000, p_q};
  assign t_a     = p_ext * CNT_W'(SAMPLE_A);
  assign t_b     = p_ext * CNT_W'(SAMPLE_B);
  assign t_c     = p_ext * CNT_W'(SAMPLE_C);
  assign t_end   = (p_ext * CNT_W'(SUBTICKS)) - CNT_W'(1);
  assign at_a    = (cnt_q == t_a);
  assign at_b    = (cnt_q == t_b);
  assign at_c    = (cnt_q == t_c);
  assign bit_end = (cnt_q == t_end);

  // The third sample is the live line value at the decision point.
  assign decided = (s_a_q & s_b_q) | (s_a_q & rxs) | (s_b_q & rxs);

  // Received parity bit compared against the parity of the shifted-in word.
  assign parity_bad = (PMODE == PAR_EVEN) ? ((^shift_q) != decided)
                                          : ((^shift_q) == decided);

  assign stop_bad_now = stop_bad_q | ~decided;

  // Next-state logic for the frame FSM, sample capture and output register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    p_d        = p_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    stop_bad_d = stop_bad_q;
    s_a_d      = s_a_q;
    s_b_d      = s_b_q;
    par_bad_d  = par_bad_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (at_a) s_a_d = rxs;
    if (at_b) s_b_d = rxs;
    if (bit_end) cnt_d = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs) begin
          // The edge cycle itself is c = 0, so the next cycle is c = 1.
          p_d        = (prescale == 16'd0) ? 16'd1 : prescale;
          cnt_d      = CNT_W'(1);
          bit_d      = '0;
          stop_idx_d = 1'b0;
          stop_bad_d = 1'b0;
          par_bad_d  = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (at_c && decided) begin
          state_d = IDLE;
        end else if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (at_c) shift_d = {decided, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            stop_idx_d = 1'b0;
            state_d    = (PMODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      PARITY: begin
        if (at_c) par_bad_d = parity_bad;
        if (bit_end) begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (at_c) begin
          if (stop_idx_q == LAST_STOP) begin
            // Frame ends at the final decision so a following start bit
            // can be caught without losing the 3p lead-in.
            if (stop_bad_now) begin
              ferr_d  = 1'b1;
              state_d = FLUSH;
            end else if (par_bad_q) begin
              perr_d  = 1'b1;
              state_d = IDLE;
            end else if (tvalid_q && !m_axis_tready) begin
              ovr_d   = 1'b1;
              state_d = IDLE;
            end else begin
              tdata_d  = shift_q;
              tvalid_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            stop_bad_d = stop_bad_now;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end

      FLUSH: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rxs_prev_q <= 1'b1;
      cnt_q      <= '0;
      p_q        <= 16'd1;
      shift_q    <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      stop_bad_q <= 1'b0;
      s_a_q      <= 1'b1;
      s_b_q      <= 1'b1;
      par_bad_q  <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxs_prev_q <= rxs;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      stop_bad_q <= stop_bad_d;
      s_a_q      <= s_a_d;
      s_b_q      <= s_b_d;
      par_bad_q  <= par_bad_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != IDLE);
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;
  assign parity_error  = perr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd4;
  logic        rxd_n = 1'b1, rxd_e = 1'b1;
  logic        tready_n = 1'b1, tready_e = 1'b1;
  logic [7:0]  tdata_n, tdata_e;
  logic        tvalid_n, tvalid_e, busy_n, busy_e;
  logic        ovr_n, ferr_n, perr_n, ovr_e, ferr_e, perr_e;

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int rise_n = -1;
  int fstart = 0;
  logic busy_seen_n = 1'b0;
  logic tv_prev_n = 1'b0;
  logic held_n = 1'b0, held_e = 1'b0;

  // Expected words and expected error codes {overrun, frame, parity}.
  logic [7:0] qd_n[$], qd_e[$];
  logic [2:0] qe_n[$], qe_e[$];

  uart_rx_cfg #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .prescale(prescale), .rxd(rxd_n),
    .m_axis_tdata(tdata_n), .m_axis_tvalid(tvalid_n), .m_axis_tready(tready_n),
    .busy(busy_n), .overrun_error(ovr_n), .frame_error(ferr_n), .parity_error(perr_n));

  uart_rx_cfg #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .prescale(prescale), .rxd(rxd_e),
    .m_axis_tdata(tdata_e), .m_axis_tvalid(tvalid_e), .m_axis_tready(tready_e),
    .busy(busy_e), .overrun_error(ovr_e), .frame_error(ferr_e), .parity_error(perr_e));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every handshake and every error pulse to the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid_n && !tv_prev_n) rise_n = cyc;
      tv_prev_n = tvalid_n;
      if (busy_n) busy_seen_n = 1'b1;
      if (tvalid_n && tready_n) begin
        if (qd_n.size() == 0) begin
          chk_cnt++;
          $display("FAIL n_extra_word: got %0h expected none", tdata_n);
        end else check("n_word", {24'd0, tdata_n}, {24'd0, qd_n.pop_front()});
      end
      if ({ovr_n, ferr_n, perr_n} != 3'b000) begin
        if (qe_n.size() == 0) begin
          chk_cnt++;
          $display("FAIL n_extra_err: got %0b expected none", {ovr_n, ferr_n, perr_n});
        end else check("n_err", {29'd0, ovr_n, ferr_n, perr_n}, {29'd0, qe_n.pop_front()});
      end
      if (tvalid_e && tready_e) begin
        if (qd_e.size() == 0) begin
          chk_cnt++;
          $display("FAIL e_extra_word: got %0h expected none", tdata_e);
        end else check("e_word", {24'd0, tdata_e}, {24'd0, qd_e.pop_front()});
      end
      if ({ovr_e, ferr_e, perr_e} != 3'b000) begin
        if (qe_e.size() == 0) begin
          chk_cnt++;
          $display("FAIL e_extra_err: got %0b expected none", {ovr_e, ferr_e, perr_e});
        end else check("e_err", {29'd0, ovr_e, ferr_e, perr_e}, {29'd0, qe_e.pop_front()});
      end
    end else begin
      tv_prev_n = 1'b0;
    end
  end

  task automatic drive_bit(input int which, input logic b, input int p);
    if (which == 0) rxd_n = b; else rxd_e = b;
    repeat (8 * p) @(posedge clk);
    #1;
  endtask

  // Reference model decides the outcome from frame contents, then the frame
  // is driven bit by bit. Called aligned to 1 time unit after a posedge.
  task automatic send_frame(input int which, input logic [7:0] data, input logic par_flip,
                            input logic [1:0] stop_bad, input int hold_low, input int gap);
    int p, nb, nst;
    logic [15:0] bits;
    logic tr, held, any_bad;
    p    = (prescale == 16'd0) ? 1 : int'(prescale);
    nst  = (which == 1) ? 2 : 1;
    bits = '0;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < 8; i++) begin bits[nb] = data[i]; nb++; end
    if (which == 1) begin bits[nb] = (^data) ^ par_flip; nb++; end
    for (int k = 0; k < nst; k++) begin bits[nb] = ~stop_bad[k]; nb++; end

    tr      = (which == 1) ? tready_e : tready_n;
    held    = (which == 1) ? held_e : held_n;
    any_bad = (which == 1) ? (stop_bad != 2'b00) : stop_bad[0];
    if (any_bad) begin
      if (which == 1) qe_e.push_back(3'b010); else qe_n.push_back(3'b010);
    end else if (which == 1 && par_flip) begin
      qe_e.push_back(3'b001);
    end else if (held && !tr) begin
      if (which == 1) qe_e.push_back(3'b100); else qe_n.push_back(3'b100);
    end else begin
      if (which == 1) begin qd_e.push_back(data); if (!tr) held_e = 1'b1; end
      else begin qd_n.push_back(data); if (!tr) held_n = 1'b1; end
    end

    fstart = cyc;
    for (int i = 0; i < nb; i++) drive_bit(which, bits[i], p);
    if (hold_low > 0) begin
      if (which == 0) rxd_n = 1'b0; else rxd_e = 1'b0;
      repeat (hold_low) @(posedge clk);
      #1;
      check("flush_busy", {31'd0, (which == 0) ? busy_n : busy_e}, 32'd1);
    end
    if (which == 0) rxd_n = 1'b1; else rxd_e = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_n_outs", {22'd0, tdata_n, tvalid_n, busy_n}, 32'd0);
    check("rst_n_errs", {29'd0, ovr_n, ferr_n, perr_n}, 32'd0);
    check("rst_e_outs", {22'd0, tdata_e, tvalid_e, busy_e}, 32'd0);
    check("rst_e_errs", {29'd0, ovr_e, ferr_e, perr_e}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // 8N1 0xA5: tvalid 309 cycles after the synchronised edge, plus 2 sync cycles.
    rise_n = -1;
    send_frame(0, 8'hA5, 1'b0, 2'b00, 0, 10);
    check("lat_8n1", 32'(rise_n - fstart), 32'd311);

    // Even parity, 0x03 with parity bit 1.
    send_frame(1, 8'h03, 1'b1, 2'b00, 0, 10);
    check("perr_busy_low", {31'd0, busy_e}, 32'd0);

    // Glitch shorter than 3p.
    busy_seen_n = 1'b0;
    rxd_n = 1'b0;
    repeat (8) @(posedge clk); #1;
    rxd_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    check("glitch_busy_seen", {31'd0, busy_seen_n}, 32'd1);
    check("glitch_busy_end", {31'd0, busy_n}, 32'd0);

    // Stop bit low, line held low, then a clean 0x3C.
    send_frame(0, 8'h96, 1'b0, 2'b01, 100, 20);
    send_frame(0, 8'h3C, 1'b0, 2'b00, 0, 10);

    // Overrun: 0x11 held, 0x22 back-to-back is dropped.
    tready_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b00, 0, 0);
    send_frame(0, 8'h22, 1'b0, 2'b00, 0, 10);
    check("ovr_held_valid", {31'd0, tvalid_n}, 32'd1);
    tready_n = 1'b1;
    held_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("ovr_drained", {31'd0, tvalid_n}, 32'd0);

    // Reset in the middle of the data bits while a word is held.
    tready_n = 1'b0;
    send_frame(0, 8'h77, 1'b0, 2'b00, 0, 4);
    check("pre_rst_valid", {31'd0, tvalid_n}, 32'd1);
    rxd_n = 1'b0;
    repeat (8 * 4 * 3) @(posedge clk); #1;
    rst = 1'b1;
    rxd_n = 1'b1;
    #1;
    check("midrst_outs", {22'd0, tdata_n, tvalid_n, busy_n}, 32'd0);
    check("midrst_errs", {29'd0, ovr_n, ferr_n, perr_n}, 32'd0);
    qd_n.delete();
    qe_n.delete();
    held_n = 1'b0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    tready_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    send_frame(0, 8'h5A, 1'b0, 2'b00, 0, 10);

    // Randomised frames, prescale 0..5, occasional parity and stop errors.
    for (int i = 0; i < 40; i++) begin
      int w, r;
      logic [1:0] sb;
      w = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      sb = 2'b00;
      if (r == 1) sb = (w == 1) ? 2'($urandom_range(1, 3)) : 2'b01;
      prescale = 16'($urandom_range(0, 5));
      send_frame(w, 8'($urandom), (w == 1 && r == 0), sb, 0,
                 (r == 1) ? 12 : $urandom_range(0, 6));
    end

    repeat (50) @(posedge clk); #1;
    check("q_n_data_empty", qd_n.size(), 32'd0);
    check("q_n_err_empty", qe_n.size(), 32'd0);
    check("q_e_data_empty", qd_e.size(), 32'd0);
    check("q_e_err_empty", qe_e.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the ALU datapath, replacing the fixed 8N1 receive path. It supports configurable data width, parity and stop bits, majority-vote bit sampling, false-start rejection, and a distinct error pulse for each failure class. It takes the board RX pin and feeds the ALU command parser over an AXI-stream master port.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5–9, LSB first.
- PARITY_MODE, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock (PLL domain).
- rst  in  1  reset, asynchronous, active-high.
- prescale  in  16  clk cycles per sub-tick (bit = 8 sub-ticks); captured at start detect; 0 treated as 1.
- rxd  in  1  serial line, idle high, asynchronous to clk.
- m_axis_tdata  out  DATA_WIDTH  received word.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  consumer accept.
- busy  out  1  frame in progress.
- overrun_error  out  1  one-cycle pulse.
- frame_error  out  1  one-cycle pulse.
- parity_error  out  1  one-cycle pulse.

## Operation
- rxd passes through a 2-flop synchroniser, reset to 1. All behaviour below refers to the synchronised signal `rxs`.
- Bit-relative cycle counter c, with p = captured prescale. Each bit is sampled at c = 3p, 4p and 5p. The majority of the three samples is the decided value at 5p. The bit ends at 8p.
- States:
  - IDLE: a 1→0 edge on rxs captures prescale, sets c = 0 and moves to START.
  - START: decided 1 → IDLE (false start, no output, no error). Decided 0 → DATA at 8p.
  - DATA: shifts DATA_WIDTH bits LSB first. Then goes to PARITY if PARITY_MODE ≠ 0, else to STOP.
  - PARITY: a mismatch is latched. Goes to STOP at 8p.
  - STOP: each stop bit is decided. The decision on the final stop bit ends the frame at 5p, not 8p, which allows back-to-back frames.
  - FLUSH: waits for rxs = 1, then → IDLE.
- Frame end priority:
  - Any stop bit decided 0: frame_error pulse, word discarded, → FLUSH.
  - Otherwise, parity mismatch: parity_error pulse, word discarded, → IDLE.
  - Otherwise, if the holding register is occupied (tvalid && !tready in that cycle): overrun_error pulse, new word discarded, old word kept, → IDLE.
  - Otherwise: load tdata, assert tvalid, → IDLE.
- A frame ending in the same cycle as a tready handshake is not an overrun. The new word is loaded and tvalid stays 1.
- tvalid holds until tready. tdata is stable while tvalid = 1.
- busy = 1 in every state except IDLE.

## Timing
- Reset values: tdata 0, tvalid 0, busy 0, all error outputs 0, state IDLE, synchroniser flops 1.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted after reset releases.
- Input latency: 2 cycles from rxd pin to rxs.
- Output latency: tvalid and error pulses are registered 1 cycle after the final decision point.
  - Final decision point = (1 + DATA_WIDTH + parity + STOP_BITS − 1)·8p + 5p cycles after the rxs falling edge.
  - 8N1 with p = 4: tvalid rises 309 cycles after the rxs falling edge.
- Glitch rejection: any low pulse shorter than 3p cycles yields no output and no error.
- Counter width is 19 bits (16-bit prescale × 8 sub-ticks). The counter must not wrap within a bit for prescale = 0xFFFF.

## Structure
- Package `uart_pkg`:
  - `parity_mode_e` enum.
  - `uart_rx_state_e` enum (IDLE, START, DATA, PARITY, STOP, FLUSH).
  - Constant SUBTICKS = 8.
  - Sample offset constants 3, 4, 5.
- Sub-module `uart_sync`: 2-flop synchroniser with parameterised reset value. Shared with a future configurable transmitter.
- Parity calculation and majority vote stay inline in `uart_rx_cfg`.

## Test plan
All scenarios use p = 4 unless stated.
- **8N1 normal receive:** send 0xA5 with tready = 1 → tvalid for 1 cycle, tdata 0xA5, 309 cycles after the synchronised edge, no errors.
- **Parity error:** DATA_WIDTH 8, even parity; send 0x03 with parity bit 1 → parity_error pulse, tvalid stays 0, busy drops.
- **Glitch rejection:** rxd low for 8 cycles then high → busy pulses, then returns to 0; no tvalid, no error pulses.
- **Frame error and line held low:** stop bit driven 0, line held low 100 cycles → exactly one frame_error pulse, busy stays 1 while the line is low. After the line returns high, 0x3C is received correctly.
- **Overrun:** tready = 0, send 0x11 then 0x22 back-to-back → tvalid with 0x11, overrun_error pulse at the end of 0x22. Raising tready consumes 0x11 and tvalid falls.
- **Reset mid-frame:** rst asserted during the data bits → all outputs 0 immediately. After release, send 0x5A → received correctly, no spurious errors.
